// File: rtl/cache_pkg.sv
// cache_pkg: shared types and default geometry for the cache miss-fill controller
package cache_pkg;
   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_WORDS_PER_BLOCK = 8;
   localparam int DEF_BLOCK_OFFSET_BITS = $clog2(2 * DEF_WORDS_PER_BLOCK);
   localparam int DEF_CNT_W = $clog2(DEF_WORDS_PER_BLOCK) + 1;
   typedef enum logic {IDLE, FILL} state_e;
endpackage

// File: rtl/fill_counter.sv
// fill_counter: saturating up-counter with synchronous clear, enable and done flag
module fill_counter #(
   parameter int W = 4,
   parameter int MAX = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o,
   output logic         done_o
);
   logic [W-1:0] cnt_q, cnt_d;
   assign done_o = cnt_q == W'(MAX);
   assign cnt_o = cnt_q;
   always_comb cnt_d = clr_i ? '0 : (en_i && !done_o) ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: fetches a whole block from pipelined memory on a miss, writes data then tag
module cache_fill_fsm
   import cache_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              miss_detected,
   input  logic [ADDR_W-1:0] miss_address,
   output logic              fsm_busy,
   output logic              memory_en,
   output logic [ADDR_W-1:0] memory_address,
   input  logic              memory_data_valid,
   input  logic [DATA_W-1:0] memory_data_out,
   output logic              write_data_array,
   output logic [ADDR_W-1:0] fill_address,
   output logic [DATA_W-1:0] fill_data,
   output logic              write_tag_array
);
   localparam int CNT_W = $clog2(WORDS_PER_BLOCK) + 1;
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(2 * WORDS_PER_BLOCK - 1);
   state_e state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [CNT_W-1:0] issue_cnt, rx_cnt;
   logic issue_done, rx_done, cnt_clr;
   fill_counter #(.W(CNT_W), .MAX(WORDS_PER_BLOCK)) u_issue_cnt (
      .clk(clk), .rst_n(rst_n), .clr_i(cnt_clr), .en_i(memory_en),
      .cnt_o(issue_cnt), .done_o(issue_done)
   );
   fill_counter #(.W(CNT_W), .MAX(WORDS_PER_BLOCK)) u_rx_cnt (
      .clk(clk), .rst_n(rst_n), .clr_i(cnt_clr), .en_i(write_data_array),
      .cnt_o(rx_cnt), .done_o(rx_done)
   );
   assign fill_data = memory_data_out;
   // Word addresses step by two bytes from the latched block base and wrap within ADDR_W.
   always_comb begin
      state_d = state_q;
      base_d = base_q;
      cnt_clr = 1'b0;
      fsm_busy = 1'b0;
      memory_en = 1'b0;
      memory_address = '0;
      write_data_array = 1'b0;
      fill_address = '0;
      write_tag_array = 1'b0;
      if (state_q == IDLE) begin
         if (miss_detected) begin
            state_d = FILL;
            base_d = miss_address & ~OFF_MASK;
            cnt_clr = 1'b1;
         end
      end else begin
         fsm_busy = 1'b1;
         memory_en = !issue_done;
         memory_address = memory_en ? base_q + ADDR_W'({issue_cnt, 1'b0}) : '0;
         write_data_array = memory_data_valid && !rx_done;
         fill_address = write_data_array ? base_q + ADDR_W'({rx_cnt, 1'b0}) : '0;
         write_tag_array = write_data_array && rx_cnt == CNT_W'(WORDS_PER_BLOCK - 1);
         state_d = write_tag_array ? IDLE : FILL;
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         base_q <= '0;
      end else begin
         state_q <= state_d;
         base_q <= base_d;
      end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: randomized fills against a transaction-level model of the miss controller
module tb_cache_fill_fsm;
   logic clk = 1'b0, rst_n = 1'b0;
   logic miss_detected = 1'b0, memory_data_valid = 1'b0;
   logic [15:0] miss_address = '0, memory_data_out = '0;
   logic fsm_busy, memory_en, write_data_array, write_tag_array;
   logic [15:0] memory_address, fill_address, fill_data;
   cache_fill_fsm dut (
      .clk(clk), .rst_n(rst_n), .miss_detected(miss_detected), .miss_address(miss_address),
      .fsm_busy(fsm_busy), .memory_en(memory_en), .memory_address(memory_address),
      .memory_data_valid(memory_data_valid), .memory_data_out(memory_data_out),
      .write_data_array(write_data_array), .fill_address(fill_address), .fill_data(fill_data),
      .write_tag_array(write_tag_array)
   );
   always #5 clk = ~clk;
   int checks = 0, errors = 0, cyc = 0, last_ret = 0;
   bit ret_v [0:16383];
   logic [15:0] ret_d [0:16383];
   bit m_busy = 0, drive_miss = 0, stray = 0;
   logic [15:0] m_base = '0, drive_addr = '0;
   int m_req = 0, m_rx = 0, cur_l = 1, acc_cyc = 0, busy_cnt = 0, dut_wr = 0, dut_tag_cyc = 0;
   logic [7:0] cur_gap = '0;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask
   task automatic step();
      bit v, e_en, e_wr, e_tag;
      int t;
      @(negedge clk);
      cyc++;
      miss_detected = drive_miss;
      miss_address = drive_addr;
      v = ret_v[cyc] || stray;
      memory_data_valid = v;
      memory_data_out = ret_v[cyc] ? ret_d[cyc] : 16'($urandom);
      #1;
      e_en = m_busy && m_req < 8;
      e_wr = m_busy && v && m_rx < 8;
      e_tag = e_wr && m_rx == 7;
      check("busy", fsm_busy, m_busy);
      check("mem_en", memory_en, e_en);
      check("mem_addr", memory_address, e_en ? m_base + 16'(2 * m_req) : 16'h0);
      check("wr_data", write_data_array, e_wr);
      check("fill_addr", fill_address, e_wr ? m_base + 16'(2 * m_rx) : 16'h0);
      if (e_wr) check("fill_data", fill_data, ret_d[cyc]);
      check("tag", write_tag_array, e_tag);
      if (fsm_busy) busy_cnt++;
      if (write_data_array) dut_wr++;
      if (write_tag_array) dut_tag_cyc = cyc;
      if (!m_busy) begin
         if (miss_detected) begin
            m_busy = 1;
            m_base = miss_address & 16'hFFF0;
            m_req = 0;
            m_rx = 0;
            acc_cyc = cyc;
            busy_cnt = 0;
            dut_wr = 0;
         end
      end else begin
         if (e_en) begin
            t = cyc + cur_l + (cur_gap[m_req] ? 2 : 0);
            if (t <= last_ret) t = last_ret + 1;
            ret_v[t] = 1;
            ret_d[t] = 16'($urandom);
            last_ret = t;
            m_req++;
         end
         if (e_wr) m_rx++;
         if (e_tag) m_busy = 0;
      end
   endtask
   task automatic run_fill(input logic [15:0] addr, input int lat, input logic [7:0] gap,
                           input bit keep, input logic [15:0] alt_addr, input int alt_after);
      int n;
      cur_l = lat;
      cur_gap = gap;
      drive_addr = addr;
      drive_miss = 1;
      n = 0;
      while (!m_busy && n < 20) begin step(); n++; end
      if (!keep) drive_miss = 0;
      n = 0;
      while (m_busy && n < 200) begin
         step();
         n++;
         if (alt_after != 0 && n == alt_after) drive_addr = alt_addr;
      end
      check("n_writes", dut_wr, 8);
      if (gap == 0) begin
         check("tag_cycle", dut_tag_cyc - acc_cyc, 8 + lat);
         check("busy_len", busy_cnt, 8 + lat);
      end
   endtask
   initial begin
      for (int i = 0; i < 16384; i++) ret_v[i] = 0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_busy", fsm_busy, 0);
      check("rst_en", memory_en, 0);
      check("rst_maddr", memory_address, 0);
      check("rst_wr", write_data_array, 0);
      check("rst_faddr", fill_address, 0);
      check("rst_tag", write_tag_array, 0);
      rst_n = 1'b1;
      repeat (2) step();
      run_fill(16'h1236, 4, 8'h00, 0, 16'h0, 0);
      step();
      run_fill(16'h1236, 4, 8'b0100_1000, 0, 16'h0, 0);
      step();
      run_fill(16'h1236, 3, 8'h00, 1, 16'h4000, 4);
      run_fill(16'h4000, 2, 8'h00, 0, 16'h0, 0);
      step();
      stray = 1;
      step();
      stray = 0;
      step();
      run_fill(16'h2468, 1, 8'h00, 0, 16'h0, 0);
      step();
      cur_l = 2;
      cur_gap = '0;
      drive_addr = 16'h1234;
      drive_miss = 1;
      for (int n = 0; n < 20 && !m_busy; n++) step();
      drive_miss = 0;
      for (int n = 0; n < 50 && m_rx < 3; n++) step();
      #1 rst_n = 1'b0;
      #1;
      check("arst_busy", fsm_busy, 0);
      check("arst_en", memory_en, 0);
      check("arst_maddr", memory_address, 0);
      check("arst_wr", write_data_array, 0);
      check("arst_faddr", fill_address, 0);
      check("arst_tag", write_tag_array, 0);
      m_busy = 0;
      #1 rst_n = 1'b1;
      repeat (12) step();
      run_fill(16'h0008, 3, 8'h00, 0, 16'h0, 0);
      step();
      run_fill(16'hFFFA, 3, 8'h00, 0, 16'h0, 0);
      for (int k = 0; k < 25; k++) begin
         for (int j = $urandom_range(0, 3); j > 0; j--) begin
            stray = 1'($urandom_range(0, 1));
            step();
         end
         stray = 0;
         run_fill(16'($urandom), $urandom_range(1, 6),
                  $urandom_range(0, 1) ? 8'($urandom) : 8'h00, 0, 16'h0, 0);
      end
      repeat (3) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
